// File: rtl/approx_mult_writeback_if.sv
// rtl/approx_mult_writeback_if.sv - operand handshake and output RAM write bus of approx_mult_writeback
interface approx_mult_writeback_if #(
    parameter int MANT_WIDTH = 8,
    parameter int SH_WIDTH   = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int RES_WIDTH  = 32
);
    logic                  start;
    logic                  in_valid;
    logic                  in_ready;
    logic [MANT_WIDTH-1:0] mant_a;
    logic [MANT_WIDTH-1:0] mant_b;
    logic [SH_WIDTH-1:0]   shamt_a;
    logic [SH_WIDTH-1:0]   shamt_b;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [RES_WIDTH-1:0]  wr_data;
    logic                  busy;
    logic                  done;

    modport master (
        output start, in_valid, mant_a, mant_b, shamt_a, shamt_b,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done
    );

    modport slave (
        input  start, in_valid, mant_a, mant_b, shamt_a, shamt_b,
        output in_ready, wr_en, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/approx_mult_writeback.sv
// rtl/approx_mult_writeback.sv - shift-add mantissa multiply, rescale, batch write to output RAM (option: APPROX_ROUND_EN)
module approx_mult_writeback #(
    parameter int MANT_WIDTH = 8,
    parameter int SH_WIDTH   = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int RES_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    approx_mult_writeback_if.slave   bus
);
    localparam int PROD_W = 2 * MANT_WIDTH;
    localparam int STEP_W = $clog2(MANT_WIDTH);
    localparam int K_W    = SH_WIDTH + 1;
    localparam int SUM_W  = RES_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, MULT, WRITE, DONE} state_t;

    state_t                state, state_next;
    logic [MANT_WIDTH-1:0] a_q;
    logic [MANT_WIDTH-1:0] b_q;
    logic [K_W-1:0]        k_q;
    logic [PROD_W-1:0]     acc;
    logic [STEP_W-1:0]     step;
    logic [ADDR_WIDTH-1:0] addr;
    logic [SUM_W-1:0]      scaled;
    logic [RES_WIDTH-1:0]  result;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; start overrides everything, including a same-cycle handshake
    always_comb begin
        state_next = state;
        if (bus.start) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.in_valid) state_next = MULT;
                MULT:    if (step == STEP_W'(MANT_WIDTH - 1)) state_next = WRITE;
                WRITE:   state_next = (addr == {ADDR_WIDTH{1'b1}}) ? DONE : IDLE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Operand capture, LSB-first shift-add on mant_b, and the batch address counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            k_q  <= '0;
            acc  <= '0;
            step <= '0;
            addr <= '0;
        end else if (bus.start) begin
            addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q  <= bus.mant_a;
                        b_q  <= bus.mant_b;
                        k_q  <= K_W'(bus.shamt_a) + K_W'(bus.shamt_b);
                        acc  <= '0;
                        step <= '0;
                    end
                end
                MULT: begin
                    if (b_q[step]) begin
                        acc <= acc + (PROD_W'(a_q) << step);
                    end
                    step <= step + STEP_W'(1);
                end
                WRITE:   addr <= addr + ADDR_WIDTH'(1);
                default: ;
            endcase
        end
    end

    // Rescale the mantissa product back to the magnitude of the original operands
    always_comb begin
        scaled = {1'b0, acc, {(RES_WIDTH - PROD_W){1'b0}}};
`ifdef APPROX_ROUND_EN
        if (k_q != '0) begin
            scaled = scaled + (SUM_W'(1) << (k_q - K_W'(1)));
        end
`else
`endif
        result = RES_WIDTH'(scaled >> k_q);
    end

    // Outputs decoded from the state register; in_ready held low while reset is applied
    always_comb begin
        bus.in_ready = (state == IDLE) && !rst;
        bus.wr_en    = (state == WRITE);
        bus.busy     = (state == MULT) || (state == WRITE);
        bus.done     = (state == DONE);
        bus.wr_addr  = addr;
        bus.wr_data  = (state == WRITE) ? result : '0;
    end
endmodule

// File: tb/tb_approx_mult_writeback.sv
// tb/tb_approx_mult_writeback.sv - scoreboard bench for approx_mult_writeback
module tb_approx_mult_writeback;
    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [2:0] exp_addr = 3'd0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    approx_mult_writeback_if bus ();

    approx_mult_writeback dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] sa, input logic [3:0] sb);
        logic [63:0] full;
        int k;
        full = 64'(a) * 64'(b);
        full = full << 16;
        k = int'(sa) + int'(sb);
`ifdef APPROX_ROUND_EN
        if (k > 0) full = full + (64'd1 << (k - 1));
`endif
        full = full >> k;
        return full[31:0];
    endfunction

    task automatic push_exp(input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] sa, input logic [3:0] sb);
        exp_t e;
        e.addr = exp_addr;
        e.data = model(a, b, sa, sb);
        sb_q.push_back(e);
        exp_addr = exp_addr + 3'd1;
    endtask

    task automatic drive_ops(input logic [7:0] a, input logic [7:0] b,
                             input logic [3:0] sa, input logic [3:0] sb);
        bus.mant_a  = a;
        bus.mant_b  = b;
        bus.shamt_a = sa;
        bus.shamt_b = sb;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL %s ready_timeout in_ready %b required 1", tag, bus.in_ready);
        end
    endtask

    task automatic do_txn(input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] sa, input logic [3:0] sb, input string tag);
        int   n;
        logic last;
        exp_t e;
        wait_ready(tag);
        drive_ops(a, b, sa, sb);
        bus.in_valid = 1'b1;
        @(posedge clk);
        push_exp(a, b, sa, sb);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_first_cycle got %b required 1", tag, bus.busy);
        end
        n = 1;
        while (bus.wr_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 9) begin
            errors++;
            $display("FAIL %s write_latency got %0d required 9", tag, n);
        end
        if (bus.wr_en === 1'b1 && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (bus.wr_addr !== e.addr) begin
                errors++;
                $display("FAIL %s wr_addr got %0d required %0d", tag, bus.wr_addr, e.addr);
            end
            checks++;
            if (bus.wr_data !== e.data) begin
                errors++;
                $display("FAIL %s wr_data got %h required %h", tag, bus.wr_data, e.data);
            end
            last = (e.addr == 3'd7);
            @(negedge clk);
            checks++;
            if ({bus.in_ready, bus.done} !== (last ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL %s after_write ready_done got %b required %b", tag,
                         {bus.in_ready, bus.done}, (last ? 2'b01 : 2'b10));
            end
            if (last) @(negedge clk);
        end else begin
            sb_q.delete();
        end
    endtask

    task automatic pulse_start;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        exp_addr = 3'd0;
    endtask

    task automatic expect_no_write(input int cycles, input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (bus.wr_en === 1'b1) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL %s unexpected_writes got %0d required 0", tag, seen);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.wr_en, bus.busy, bus.done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset ready_wren_busy_done got %b required 0000",
                     {bus.in_ready, bus.wr_en, bus.busy, bus.done});
        end
        checks++;
        if (bus.wr_addr !== 3'd0) begin
            errors++;
            $display("FAIL reset wr_addr got %0d required 0", bus.wr_addr);
        end
        checks++;
        if (bus.wr_data !== 32'd0) begin
            errors++;
            $display("FAIL reset wr_data got %h required 0", bus.wr_data);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release in_ready got %b required 1", bus.in_ready);
        end
        exp_addr = 3'd0;
    endtask

    task automatic test_vectors;
        do_txn(8'h80, 8'h80, 4'd0,  4'd0,  "unity");
        do_txn(8'hC0, 8'hFF, 4'd8,  4'd8,  "mid_shift");
        do_txn(8'hFF, 8'hFF, 4'd15, 4'd15, "max_shift");
        do_txn(8'h00, 8'hA5, 4'd3,  4'd1,  "zero_a");
        do_txn(8'h9C, 8'h00, 4'd0,  4'd7,  "zero_b");
        for (int i = 0; i < 3; i++) begin
            do_txn(8'($urandom_range(128, 255)), 8'($urandom_range(128, 255)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "random");
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] a, b;
        logic [3:0] sa, sb;
        int   cyc, accepted, writes, last_wr, done_cnt, gap;
        logic prev7, hs;
        exp_t e;
        pulse_start();
        a = 8'($urandom_range(128, 255));
        b = 8'($urandom_range(128, 255));
        sa = 4'($urandom_range(0, 15));
        sb = 4'($urandom_range(0, 15));
        drive_ops(a, b, sa, sb);
        bus.in_valid = 1'b1;
        cyc = 0; accepted = 0; writes = 0; last_wr = -100; done_cnt = 0; prev7 = 1'b0;
        while (writes < 9 && cyc < 200) begin
            if (bus.done === 1'b1) begin
                done_cnt++;
                checks++;
                if (!(prev7 && cyc == last_wr + 1)) begin
                    errors++;
                    $display("FAIL b2b done_timing got cycle %0d required %0d", cyc, last_wr + 1);
                end
            end
            if (bus.wr_en === 1'b1 && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (bus.wr_addr !== e.addr) begin
                    errors++;
                    $display("FAIL b2b wr_addr got %0d required %0d", bus.wr_addr, e.addr);
                end
                checks++;
                if (bus.wr_data !== e.data) begin
                    errors++;
                    $display("FAIL b2b wr_data got %h required %h", bus.wr_data, e.data);
                end
                if (writes > 0) begin
                    gap = prev7 ? 11 : 10;
                    checks++;
                    if (cyc - last_wr != gap) begin
                        errors++;
                        $display("FAIL b2b write_spacing got %0d required %0d", cyc - last_wr, gap);
                    end
                end
                prev7 = (e.addr == 3'd7);
                last_wr = cyc;
                writes++;
            end
            hs = (bus.in_ready === 1'b1) && bus.in_valid;
            if (hs) begin
                push_exp(a, b, sa, sb);
                accepted++;
            end
            @(posedge clk);
            #1;
            if (hs) begin
                if (accepted == 9) bus.in_valid = 1'b0;
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
                sa = 4'($urandom_range(0, 15));
                sb = 4'($urandom_range(0, 15));
                drive_ops(a, b, sa, sb);
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (writes != 9) begin
            errors++;
            $display("FAIL b2b write_count got %0d required 9", writes);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL b2b done_count got %0d required 1", done_cnt);
        end
        sb_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_start_abort;
        do_txn(8'hAA, 8'h55, 4'd2, 4'd2, "pre_abort");
        wait_ready("abort");
        drive_ops(8'hF0, 8'hE1, 4'd1, 4'd1);
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        exp_addr = 3'd0;
        checks++;
        if ({bus.busy, bus.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL abort state busy_ready got %b required 01", {bus.busy, bus.in_ready});
        end
        expect_no_write(12, "abort");
        do_txn(8'h81, 8'hC3, 4'd4, 4'd5, "post_abort");
    endtask

    task automatic test_start_priority;
        int busy_seen;
        do_txn(8'h90, 8'h90, 4'd1, 4'd0, "pre_prio");
        drive_ops(8'hFF, 8'hFF, 4'd0, 4'd0);
        bus.start = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        exp_addr = 3'd0;
        busy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) busy_seen++;
            @(negedge clk);
        end
        checks++;
        if (busy_seen != 0) begin
            errors++;
            $display("FAIL prio pair_accepted got %0d busy cycles required 0", busy_seen);
        end
        do_txn(8'hB7, 8'hD2, 4'd6, 4'd3, "post_prio");
    endtask

    task automatic test_reset_mid;
        do_txn(8'hC8, 8'h8C, 4'd9, 4'd2, "pre_rst");
        wait_ready("rst_mid");
        drive_ops(8'hEE, 8'hDD, 4'd0, 4'd0);
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.in_ready, bus.wr_en, bus.busy, bus.done} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid ready_wren_busy_done got %b required 0000",
                     {bus.in_ready, bus.wr_en, bus.busy, bus.done});
        end
        checks++;
        if ({bus.wr_addr, bus.wr_data} !== 35'd0) begin
            errors++;
            $display("FAIL rst_mid addr_data got %0d/%h required 0/0", bus.wr_addr, bus.wr_data);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_addr = 3'd0;
        sb_q.delete();
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid in_ready got %b required 1", bus.in_ready);
        end
        expect_no_write(12, "rst_mid");
        do_txn(8'hA1, 8'hB2, 4'd5, 4'd10, "post_rst");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        drive_ops(8'h00, 8'h00, 4'd0, 4'd0);
        @(negedge clk);
        test_reset();
        test_vectors();
        test_back_to_back();
        test_start_abort();
        test_start_priority();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/approx_mult_writeback.md
# approx_mult_writeback

Downstream stage of the approximate-multiplier datapath. It accepts one pair of normalized 8-bit mantissas per transaction, each with its leading-one shift count from the two 16-bit shift-register/counter paths. It forms the 16-bit product with a sequential shift-add multiplier and rescales it to the 32-bit approximate product of the original 16-bit operands. It writes the result to the output RAM at an auto-incrementing address and pulses `done` after the eighth write.

## Interface
Parameters:
- `MANT_WIDTH`, 8, mantissa width (top bits of each normalized 16-bit operand)
- `SH_WIDTH`, 4, width of each shift count (0..15)
- `ADDR_WIDTH`, 3, output RAM address width; one batch = 2^ADDR_WIDTH results
- `RES_WIDTH`, 32, product/result width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse: begin new batch (clear address, abort in-flight op)
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  block can accept a pair
- `mant_a`, `mant_b`  in  MANT_WIDTH  normalized mantissas (bits [15:8] after normalization)
- `shamt_a`, `shamt_b`  in  SH_WIDTH  left-shift counts applied during normalization
- `wr_en`  out  1  output RAM write strobe
- `wr_addr`  out  ADDR_WIDTH  output RAM address
- `wr_data`  out  RES_WIDTH  approximate product
- `busy`  out  1  high in MULT and WRITE states
- `done`  out  1  one-cycle pulse after the last write of a batch

## Operation
- FSM states: IDLE, MULT, WRITE, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready` at a rising edge: latch the mantissas, store `k = shamt_a + shamt_b` (5 bits, 0..30), clear the 16-bit accumulator and the 3-bit step counter, then go to MULT.
- MULT: one shift-add step per cycle, LSB-first on `mant_b`, for exactly 8 cycles. The step counter reaching 7 moves the FSM to WRITE.
- WRITE:
  - `wr_en`=1 for one cycle.
  - `wr_data = ({prod, 16'b0}) >> k`, a 32-bit logical right shift. This is exact for k ≤ 16; below-LSB bits are truncated.
  - `wr_addr` = current address counter. The counter increments at the end of WRITE and wraps 7 → 0.
  - If the written address was 2^ADDR_WIDTH−1, go to DONE; otherwise go to IDLE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` (any state):
  - Forces IDLE on the next edge and clears the address counter.
  - An in-flight operation is discarded with no write.
  - `start` has priority over a same-cycle handshake; that pair is not accepted.
- `in_valid` is ignored outside IDLE. Operands are not re-sampled after acceptance.
- `mant_a = 0` or `mant_b = 0` yields `wr_data = 0`, with no special path.

## Timing
- Reset values: `in_ready`=0 while `rst` is asserted, 1 from the first cycle after release. `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0. Address counter = 0.
- Latency: handshake at edge T. `busy` is high in cycles T+1..T+9. `wr_en` is high in cycle T+9, counting cycles as the interval following each edge. `in_ready` returns high in cycle T+10, or T+11 if the write ended a batch.
- Throughput: one result per 10 cycles; one per 11 cycles for the batch-ending result.
- All outputs are registered or decoded from the state register. No combinational path from `in_valid` to `in_ready`.
- `rst` asserted mid-operation: immediate return to reset values. A write is never partially issued.

## Configuration
- `APPROX_ROUND_EN` defined:
  - In WRITE, add `1 << (k-1)` to `{prod,16'b0}` before the shift when k > 0. This rounds half-up.
  - The addition is 33 bits wide and the result is truncated to 32 bits; overflow is impossible for 8-bit mantissas.
- Undefined: pure truncation as described above. Cycle timing is identical in both builds.

## Test plan
- `mant_a`=0x80, `shamt_a`=0, `mant_b`=0x80, `shamt_b`=0 -> `wr_en` in cycle T+9, `wr_data`=0x40000000, `wr_addr`=0.
- `mant_a`=0xC0, `shamt_a`=8, `mant_b`=0xFF, `shamt_b`=8 -> `wr_data`=0x0000BF40 (192×255). Same in both builds.
- `mant_a`=0xFF, `shamt_a`=15, `mant_b`=0xFF, `shamt_b`=15 -> `wr_data`=3 without `APPROX_ROUND_EN`, 4 with it.
- Eight back-to-back pairs with `in_valid` held high -> writes to addresses 0..7 at 10-cycle spacing. `done` pulses one cycle after the address-7 write. A ninth pair writes to address 0.
- `start` pulsed in the 4th MULT cycle -> no `wr_en`, IDLE next cycle, `wr_addr`=0 on the next write. `rst` pulsed mid-MULT -> all outputs at reset values asynchronously.
- `start` and `in_valid` both high in IDLE -> pair not accepted, `busy` stays 0, the address counter cleared.
